// File: rtl/uart_tx_arb_if.sv
// Requester streams plus the transmitter load/busy handshake shared by uart_tx_arb.
// The master side is the requesters and the UART together; the slave side is the arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one UART transmitter byte by byte, with optional source-ID header.
// States: IDLE arbitrate | HDR load header | FETCH take byte | ISSUE load pulse | WAIT_HI/WAIT_LO track busy.
module uart_tx_arb #(
  parameter int          NUM_REQ  = 4,
  parameter int          HDR_EN   = 1,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.slave  bus,
  output logic [2:0]    grant_id,
  output logic          active,
  output logic [15:0]   pkt_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    FETCH   = 3'd2,
    ISSUE   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   grant_q, grant_d;
  logic [2:0]   rr_ptr_q, rr_ptr_d;
  logic         active_q, active_d;
  logic [15:0]  pkt_count_q, pkt_count_d;
  logic [7:0]   hold_byte_q, hold_byte_d;
  logic         hold_last_q, hold_last_d;
  logic [7:0]   tx_data_q, tx_data_d;

  logic               found;
  logic [2:0]         pick;
  logic [NUM_REQ-1:0] grant_oh;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;

  // Two passes: lanes at or above rr_ptr first, then the wrapped-around lanes below it.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (3'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        grant_oh[i] = 1'b1;
        sel_valid   = bus.req_valid[i];
        sel_data    = bus.req_data[8*i +: 8];
        sel_last    = bus.req_last[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    active_d      = active_q;
    pkt_count_d   = pkt_count_q;
    hold_byte_d   = hold_byte_q;
    hold_last_d   = hold_last_q;
    tx_data_d     = tx_data_q;
    bus.req_ready = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = tx_data_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          active_d = 1'b1;
          state_d  = (HDR_EN != 0) ? HDR : FETCH;
        end
      end
      HDR: begin
        hold_byte_d = HDR_BASE | {5'b00000, grant_q};
        hold_last_d = 1'b0;
        state_d     = ISSUE;
      end
      FETCH: begin
        bus.req_ready = grant_oh;
        if (sel_valid) begin
          hold_byte_d = sel_data;
          hold_last_d = sel_last;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // tx_data is muxed straight from hold_byte during the pulse so it lines up with tx_valid.
        if (!bus.tx_busy) begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = hold_byte_q;
          tx_data_d    = hold_byte_q;
          state_d      = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (hold_last_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
            rr_ptr_d    = (grant_q == 3'(NUM_REQ-1)) ? 3'd0 : grant_q + 3'd1;
            active_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 3'd0;
      rr_ptr_q    <= 3'd0;
      active_q    <= 1'b0;
      pkt_count_q <= 16'd0;
      hold_byte_q <= 8'h00;
      hold_last_q <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      active_q    <= active_d;
      pkt_count_q <= pkt_count_d;
      hold_byte_q <= hold_byte_d;
      hold_last_q <= hold_last_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign grant_id  = grant_q;
  assign active    = active_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-lane packet queues, a UART busy model, a vector table and corner sequences.
module tb_uart_tx_arb;

  localparam int NREQ     = 4;
  localparam int BUSY_LEN = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  grant_id;
  logic        active;
  logic [15:0] pkt_count;

  uart_tx_arb_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arb #(.NUM_REQ(NREQ), .HDR_EN(1), .HDR_BASE(8'hA0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .active    (active),
    .pkt_count (pkt_count)
  );

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } lane_item_t;

  typedef struct packed {
    logic [2:0]  lane;
    logic [3:0]  nbytes;
    logic [23:0] data;
    logic [3:0]  exp_n;
    logic [95:0] exp;
    logic [15:0] exp_cnt;
  } vec_t;

  lane_item_t     lane_q [NREQ][$];
  logic [NREQ-1:0] lane_en;
  logic [NREQ-1:0] acc;
  logic [7:0]     tx_log [$];
  logic           busy_force;
  int             busy_cnt;
  int             checks;
  int             failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester lanes: present the queue head; a byte seen valid&ready at a negedge is taken at the next posedge.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    acc = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        if (lane_en[i] && lane_q[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = lane_q[i][0].data;
          bus.req_last[i]        = lane_q[i][0].last;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
        acc[i] = bus.req_valid[i] && bus.req_ready[i] && !rst;
      end
    end
  end

  // UART model: logs every loaded byte, then holds busy high for BUSY_LEN cycles starting next cycle.
  initial begin
    bus.tx_busy = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        bus.tx_busy = 1'b1;
      end else begin
        bus.tx_busy = busy_force;
      end
      #1;
      if (bus.tx_valid) begin
        tx_log.push_back(bus.tx_data);
        busy_cnt = BUSY_LEN;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] data, input logic last);
    lane_item_t it;
    it.data = data;
    it.last = last;
    lane_q[lane].push_back(it);
  endtask

  task automatic check_log(input string name, input int n, input logic [95:0] exp);
    logic [63:0] act;
    check({name, "_len"}, 64'(tx_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      act = (i < tx_log.size()) ? 64'(tx_log[i]) : 64'hDEAD;
      check($sformatf("%s_byte%0d", name, i), act, 64'(exp[95-8*i -: 8]));
    end
  endtask

  task automatic wait_count(input string name, input logic [15:0] target, input int budget);
    int n;
    n = 0;
    while (pkt_count !== target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_pkt_count"}, 64'(pkt_count), 64'(target));
  endtask

  task automatic wait_log(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (tx_log.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_log_reached"}, 64'(tx_log.size() >= target), 64'd1);
  endtask

  initial begin
    vec_t tbl [4];
    int   lat;
    int   highs;

    tbl[0] = '{3'd2, 4'd2, 24'h112200, 4'd3, {8'hA2, 8'h11, 8'h22, 72'h0},          16'd1};
    tbl[1] = '{3'd0, 4'd1, 24'h5A0000, 4'd2, {8'hA0, 8'h5A, 80'h0},                 16'd2};
    tbl[2] = '{3'd3, 4'd3, 24'h010203, 4'd4, {8'hA3, 8'h01, 8'h02, 8'h03, 64'h0},   16'd3};
    tbl[3] = '{3'd1, 4'd2, 24'hFF0000, 4'd3, {8'hA1, 8'hFF, 8'h00, 72'h0},          16'd4};

    checks = 0;
    failures = 0;
    busy_force = 1'b0;
    lane_en = '1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_active", 64'(active), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);

    for (int r = 0; r < 4; r++) begin
      tx_log.delete();
      for (int j = 0; j < int'(tbl[r].nbytes); j++)
        push(int'(tbl[r].lane), tbl[r].data[23-8*j -: 8], j == int'(tbl[r].nbytes) - 1);
      lat = 0;
      while (!bus.req_valid[tbl[r].lane] && lat < 10) begin
        tick();
        lat++;
      end
      lat = 0;
      while (!bus.tx_valid && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_hdr_latency", r), 64'(lat), 64'd2);
      wait_count($sformatf("vec%0d", r), tbl[r].exp_cnt, 400);
      check($sformatf("vec%0d_active", r), 64'(active), 64'd0);
      check($sformatf("vec%0d_grant", r), 64'(grant_id), 64'(tbl[r].lane));
      check_log($sformatf("vec%0d_log", r), int'(tbl[r].exp_n), tbl[r].exp);
    end

    // All four lanes requesting from reset are served 0,1,2,3.
    rst = 1'b1;
    tx_log.delete();
    for (int i = 0; i < NREQ; i++) push(i, 8'h10 + 8'(i), 1'b1);
    tick();
    tick();
    rst = 1'b0;
    wait_count("all4", 16'd4, 800);
    check("all4_grant", 64'(grant_id), 64'd3);
    check_log("all4_log", 8, {8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 32'h0});

    // Lane 1 keeps requesting; lane 3 must still get its turn in between.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_log.delete();
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    push(1, 8'h34, 1'b0); push(1, 8'h35, 1'b0); push(1, 8'h36, 1'b1);
    push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b1);
    wait_count("rr", 16'd3, 1200);
    check_log("rr_log", 11, {8'hA1, 8'h31, 8'h32, 8'h33, 8'hA3, 8'h71, 8'h72,
                             8'hA1, 8'h34, 8'h35, 8'h36, 8'h00});

    // Granted lane stalls for 50 cycles between bytes.
    tx_log.delete();
    push(0, 8'h40, 1'b0);
    wait_log("stall", 2, 200);
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.tx_valid) highs++;
    end
    check("stall_tx_valid", 64'(highs), 64'd0);
    check("stall_req_ready", 64'(bus.req_ready), 64'b0001);
    check("stall_active", 64'(active), 64'd1);
    check("stall_grant", 64'(grant_id), 64'd0);
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    wait_count("stall", 16'd4, 400);
    check_log("stall_log", 4, {8'hA0, 8'h40, 8'h41, 8'h42, 64'h0});

    // Busy held high while a byte is ready: no pulse until it falls.
    tx_log.delete();
    busy_force = 1'b1;
    push(2, 8'h5C, 1'b1);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.tx_valid) highs++;
    end
    check("busyhold_tx_valid", 64'(highs), 64'd0);
    check("busyhold_log_empty", 64'(tx_log.size()), 64'd0);
    busy_force = 1'b0;
    wait_count("busyhold", 16'd5, 400);
    check_log("busyhold_log", 2, {8'hA2, 8'h5C, 80'h0});

    // Reset during WAIT_LO of a 4-byte packet; rr_ptr was 3 before it.
    tx_log.delete();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b0); push(1, 8'h64, 1'b1);
    wait_log("midrst", 2, 200);
    tick();
    tick();
    check("midrst_active_before", 64'(active), 64'd1);
    rst = 1'b1;
    lane_en = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) lane_q[i].delete();
    lane_en = '1;
    check("midrst_active", 64'(active), 64'd0);
    check("midrst_grant", 64'(grant_id), 64'd0);
    check("midrst_pkt_count", 64'(pkt_count), 64'd0);
    check("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("midrst_tx_data", 64'(bus.tx_data), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    tx_log.delete();
    push(0, 8'h70, 1'b1);
    push(3, 8'h73, 1'b1);
    wait_count("midrst_after", 16'd2, 600);
    check_log("midrst_log", 4, {8'hA0, 8'h70, 8'hA3, 8'h73, 64'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
